rotate_seq_ctrl: RTL

Command-driven sequencer for a WIDTH-bit circular shift register. It accepts a load command containing a pattern, direction, step count and step-rate divider. It then rotates the pattern the requested number of steps at the programmed rate and signals completion. It sits between control logic (LED marquee, test-pattern, or scan sequencing) and the rotating datapath, and supplies the per-step load/rotate sequencing that a free-running rotator lacks.

---
 rtl/rotate_seq_ctrl.sv | 67 ++++++
 1 files changed

// File: rtl/rotate_seq_ctrl.sv
// rotate_seq_ctrl: command-driven WIDTH-bit rotator sequencer (i_start/i_pattern/i_dir/i_steps/i_div/i_abort in; o_ready/o_busy/o_done/o_dout out)
module rotate_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_steps,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_abort,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_dout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic             dir_q;
  logic [CNT_W-1:0] steps_q, step_cnt, step_nxt;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [WIDTH-1:0] rot;
  assign step_nxt = step_cnt + 1'b1;
  assign rot = dir_q ? {o_dout[0], o_dout[WIDTH-1:1]} : {o_dout[WIDTH-2:0], o_dout[WIDTH-1]};
  assign o_ready = state == IDLE;
  assign o_busy = state != IDLE;
  assign o_done = state == DONE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      o_dout <= '0;
      dir_q <= 1'b0;
      steps_q <= '0;
      div_q <= '0;
      step_cnt <= '0;
      div_cnt <= '0;
    end else if (state == IDLE) begin
      if (i_start) begin
        dir_q <= i_dir;
        steps_q <= i_steps;
        div_q <= i_div;
        o_dout <= i_pattern;
        step_cnt <= '0;
        div_cnt <= '0;
        state <= (i_steps == '0) ? DONE : RUN;
      end
    end else if (state == RUN) begin
      if (i_abort) begin
        state <= IDLE;
      end else if (div_cnt == div_q) begin
        o_dout <= rot;
        div_cnt <= '0;
        step_cnt <= step_nxt;
        if (step_nxt == steps_q) state <= DONE;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule
